// File: rtl/midori128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : midori128_pkg
// Description : Shared types, constants and the column-mix function for the
//               serialized Midori128 MixColumn stage.
// Contents    : mc_state_t  - control FSM state encoding (IDLE/BUSY/DONE)
//               CELL_W, COL_W, NUM_COLS, STATE_W - datapath geometry
//               mix_column  - M = circ(0,1,1,1) applied to one 32-bit column
// Revision    : 1.0 - initial release
// ============================================================================
package midori128_pkg;

  localparam int CELL_W   = 8;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int STATE_W  = NUM_COLS * COL_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  // Each output cell is the XOR of the other three input cells of the
  // column. The matrix is involutory, so applying it twice is the identity.
  function automatic logic [COL_W-1:0] mix_column(input logic [COL_W-1:0] a);
    logic [CELL_W-1:0] a0;
    logic [CELL_W-1:0] a1;
    logic [CELL_W-1:0] a2;
    logic [CELL_W-1:0] a3;
    a0 = a[0*CELL_W +: CELL_W];
    a1 = a[1*CELL_W +: CELL_W];
    a2 = a[2*CELL_W +: CELL_W];
    a3 = a[3*CELL_W +: CELL_W];
    mix_column = {a0 ^ a1 ^ a2,   // y3
                  a0 ^ a1 ^ a3,   // y2
                  a0 ^ a2 ^ a3,   // y1
                  a1 ^ a2 ^ a3};  // y0
  endfunction

endpackage
`default_nettype wire

// File: rtl/midori128_mc_column.sv
`default_nettype none
// ============================================================================
// Module      : midori128_mc_column
// Description : Purely combinational Midori128 column mixer (one 32-bit
//               column, four 8-bit cells, XOR only).
// Ports       : i_col [31:0] - input column, cell k at bits [8k+7:8k]
//               o_col [31:0] - mixed column, same cell layout
// Revision    : 1.0 - initial release
// ============================================================================
module midori128_mc_column
  import midori128_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
  output logic [COL_W-1:0] o_col
);

  assign o_col = mix_column(i_col);

endmodule
`default_nettype wire

// File: rtl/midori128_mixcolumn_serial.sv
`default_nettype none
// ============================================================================
// Module      : midori128_mixcolumn_serial
// Description : Serialized Midori128 MixColumn stage. Accepts a 128-bit
//               shuffled state over a valid/ready handshake, mixes
//               COLS_PER_CYCLE columns per BUSY cycle in place, then offers
//               the mixed state downstream over a second valid/ready pair.
// Parameters  : COLS_PER_CYCLE - 1, 2 or 4 columns mixed per BUSY cycle
// Ports       : clk, rst            - clock, async active-high reset
//               in_valid/in_ready   - upstream handshake
//               in_data [127:0]     - shuffled state (cell i = bits [8i+7:8i])
//               out_valid/out_ready - downstream handshake
//               out_data [127:0]    - state register, same layout
//               in_last             - only with MIDORI128_MC_BYPASS_EN:
//                                     state passes through unmixed
// Options     : `define MIDORI128_MC_BYPASS_EN to add the in_last bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module midori128_mixcolumn_serial
  import midori128_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
`ifdef MIDORI128_MC_BYPASS_EN
  ,
  input  logic               in_last
`endif
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guard
  // --------------------------------------------------------------------------
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
  begin : g_bad_cols_per_cycle
    $error("midori128_mixcolumn_serial: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] C_STEP = 3'(COLS_PER_CYCLE);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  mc_state_t          r_state;
  mc_state_t          w_state_next;
  logic               r_out_valid;
  logic [1:0]         r_col_cnt;
  logic [STATE_W-1:0] r_st;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_busy_step;
  logic [2:0]         w_cnt_sum;
  logic               w_last_step;
  logic               w_do_mix;
  logic [STATE_W-1:0] w_st_mixed;

  logic [1:0]         w_col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   w_col_out [COLS_PER_CYCLE];

  // --------------------------------------------------------------------------
  // Column progress. The 3-bit sum carries into bit 2 exactly when this
  // BUSY cycle covers column 3, which is the final update for the block.
  // --------------------------------------------------------------------------
  assign w_cnt_sum   = {1'b0, r_col_cnt} + C_STEP;
  assign w_last_step = w_cnt_sum[2];

  // --------------------------------------------------------------------------
  // FSM process 1: state register. out_valid is registered from the next
  // state so it is a clean flop output.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= (w_state_next == DONE);
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last_step) w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = in_valid ? BUSY : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: output / control decode. in_ready depends only on the
  // state and out_ready, never on in_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_busy_step = 1'b0;
    unique case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      BUSY:    w_busy_step = 1'b1;
      DONE:    w_in_ready  = out_ready;
      default: w_in_ready  = 1'b0;
    endcase
  end

  assign w_accept = in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // Column mixers: lane k works on column (col_cnt + k) mod 4
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_col_idx[k] = r_col_cnt + 2'(k);
    assign w_col_in[k]  = r_st[{w_col_idx[k], 5'd0} +: COL_W];

    midori128_mc_column u_column (
      .i_col (w_col_in[k]),
      .o_col (w_col_out[k])
    );
  end

  // Write the mixed lanes back over their source columns; the rest of the
  // state is carried through untouched.
  always_comb begin
    w_st_mixed = r_st;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_st_mixed[{w_col_idx[k], 5'd0} +: COL_W] = w_col_out[k];
    end
  end

  // --------------------------------------------------------------------------
  // Optional bypass: a state tagged as last still spends N cycles in BUSY
  // so its latency matches a mixed state, but r_st is simply held.
  // --------------------------------------------------------------------------
`ifdef MIDORI128_MC_BYPASS_EN
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_last <= in_last;
    end
  end

  assign w_do_mix = ~r_last;
`else
  assign w_do_mix = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Datapath: state register and column counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= '0;
      r_col_cnt <= 2'd0;
    end else if (w_accept) begin
      r_st      <= in_data;
      r_col_cnt <= 2'd0;
    end else if (w_busy_step) begin
      if (w_do_mix) r_st <= w_st_mixed;
      r_col_cnt <= w_cnt_sum[1:0];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_st;

endmodule
`default_nettype wire
